// File: rtl/uart_serial_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s); all outputs registered.
// Optional parity bit compiled in with UART_TX_PARITY_EN (odd when PARITY_ODD=1, else even).
module uart_serial_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic                 TxStart,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 TxSerial,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_serial_tx: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 serial_d, busy_d, done_d;
  logic                 bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      TxSerial <= 1'b1;
      TxBusy   <= 1'b0;
      TxDone   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      shreg    <= shreg_d;
      TxSerial <= serial_d;
      TxBusy   <= busy_d;
      TxDone   <= done_d;
    end
  end

  // idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shreg_d = shreg;
    if (state != IDLE) begin
      cnt_d = bit_end ? '0 : cnt + 1'b1;
    end
    case (state)
      IDLE: begin
        if (En && TxStart) begin
          state_d = START;
          cnt_d   = '0;
          shreg_d = TxData;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            idx_d = '0;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (idx == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered, aligned with it.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      START: serial_d = 1'b0;
      DATA:  serial_d = shreg_d[idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY: serial_d = (^shreg_d) ^ (PARITY_ODD != 0);
`endif
      default: serial_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state == STOP) && (state_d == IDLE);
  end

endmodule

// File: doc/uart_serial_tx.md
Name: uart_serial_tx

Overview:
- UART transmitter: the transmit end of the UART link, whose receiver uses a rising/falling edge detector for start-bit detection.
- Accepts one parallel byte on a start strobe and shifts it out LSB-first as start bit, data bits, optional parity bit and stop bits.
- Each bit is held for a fixed number of clock cycles.
- Sits between the loopback/user logic and the TX pin; in the loopback build its serial output feeds the receiver.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200). Legal range 2..65535.
- DATA_BITS, 8, data bits per frame. Legal range 5..8.
- STOP_BITS, 1, stop bits per frame. Legal values 1 or 2.
- PARITY_ODD, 0, 1 = odd parity, 0 = even. Used only when UART_TX_PARITY_EN is defined.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- En  input  1  transmit enable; gates acceptance of new frames only.
- TxStart  input  1  request to send TxData; sampled on rising edge of Clk.
- TxData  input  DATA_BITS  byte to send; captured on the accepting edge.
- TxSerial  output  1  serial line; idle high.
- TxBusy  output  1  high while a frame is in progress.
- TxDone  output  1  one-cycle pulse after the last stop bit.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - TxSerial = 1, TxBusy = 0, TxDone = 0.
  - State = IDLE; bit counter and cycle counter = 0.
  - Applied immediately on Rst assertion, including mid-frame. The frame is abandoned and the line returns high at once.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TxSerial = 1, TxBusy = 0.
  - If En = 1 and TxStart = 1 at edge k: latch TxData into the shift register, go to START, clear the cycle counter.
  - From the cycle after edge k: TxBusy = 1 and TxSerial = 0.
  - TxStart with En = 0 is ignored.
- START: TxSerial = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - TxSerial = shift-register bit[index], LSB first, each bit for CLKS_PER_BIT cycles.
  - After bit DATA_BITS-1, go to PARITY (feature enabled) or STOP.
- STOP:
  - TxSerial = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - Then go to IDLE: TxBusy = 0 and TxDone = 1 for exactly that one cycle.
- Cycle counter:
  - Counts 0..CLKS_PER_BIT-1; wraps to 0 at each bit boundary.
  - Width is the ceiling of log2(CLKS_PER_BIT).
- TxStart while TxBusy = 1 is ignored, with no queueing. TxData changes mid-frame have no effect.
- En deasserted mid-frame: the current frame completes normally.
- Back-to-back: a TxStart held high in the TxDone cycle is accepted on that edge.
  - Minimum frame period is FRAME_BITS*CLKS_PER_BIT + 1 cycles, with one idle-high cycle between frames.
  - FRAME_BITS = 1 + DATA_BITS + STOP_BITS (+1 with parity).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted after DATA.
  - TxSerial = XOR of the captured data bits, XOR PARITY_ODD, held for CLKS_PER_BIT cycles; then STOP.
- Undefined:
  - The PARITY state and logic are not compiled; DATA goes directly to STOP.
  - PARITY_ODD is ignored.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless noted):
- Reset then idle 20 cycles -> TxSerial=1, TxBusy=0, TxDone=0 throughout.
- En=1, TxData=8'hA5, TxStart pulse one cycle -> line 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. TxBusy high 40 cycles, then TxDone one cycle.
- TxStart pulses at cycles 5 and 20 of a frame carrying 8'h3C -> the second request is ignored. Exactly one frame is sent and only one TxDone.
- TxStart held high with TxData=8'h01, then 8'hFF after the first accept -> two frames separated by exactly 1 idle-high cycle. Second frame is 0, eight 1s, 1.
- Rst asserted at cycle 17 of a frame -> TxSerial=1 and TxBusy=0 before the next Clk edge. No TxDone. The next TxStart produces a full clean frame.
- UART_TX_PARITY_EN defined, PARITY_ODD=0, TxData=8'h07 -> parity bit = 1 after data, then stop. TxBusy high 44 cycles.
